// File: rtl/add_sequencer.sv
// add_sequencer
//
// Multi-precision add scheduler. Two requesters share one p_WIDTH-bit
// carry-lookahead adder. A granted request is captured, then added one word
// per cycle (LSB word first) with the inter-word carry held in a register.
// The (N+1)-bit result, N = p_WIDTH*p_WORDS, is presented until consumed.
//
// Handshake rules (all ports of this block):
//   A transfer happens on a rising clock edge where valid and ready are both
//   high. Requester readys are combinational, only ever high in IDLE, and
//   never high without the matching valid. At most one ready is high.
//   ow_res_valid is high only in DONE. The result is consumed on an edge with
//   iw_res_ready high, and sum/id stay stable until then.
//
// Ports:
//   iw_clk, iw_rst          clock, asynchronous active-high reset
//   iw_reqN_valid           requester N has an operation pending
//   iwv_reqN_x, iwv_reqN_y  requester N operands (N bits)
//   iw_reqN_carry           requester N carry-in
//   ow_reqN_ready           requester N accepted on this edge
//   ow_res_valid            result available
//   owv_res_sum             x + y + carry-in, bit N is the carry-out
//   ow_res_id               requester that owns the result
//   iw_res_ready            consumer takes the result
//   ow_dbg_state            current FSM state (0 IDLE, 1 RUN, 2 DONE)

module add_sequencer #(
  parameter int p_WIDTH = 8,
  parameter int p_WORDS = 4
) (
  input  logic                         iw_clk,
  input  logic                         iw_rst,
  input  logic                         iw_req0_valid,
  input  logic [p_WIDTH*p_WORDS-1:0]   iwv_req0_x,
  input  logic [p_WIDTH*p_WORDS-1:0]   iwv_req0_y,
  input  logic                         iw_req0_carry,
  output logic                         ow_req0_ready,
  input  logic                         iw_req1_valid,
  input  logic [p_WIDTH*p_WORDS-1:0]   iwv_req1_x,
  input  logic [p_WIDTH*p_WORDS-1:0]   iwv_req1_y,
  input  logic                         iw_req1_carry,
  output logic                         ow_req1_ready,
  output logic                         ow_res_valid,
  output logic [p_WIDTH*p_WORDS:0]     owv_res_sum,
  output logic                         ow_res_id,
  input  logic                         iw_res_ready,
  output logic [1:0]                   ow_dbg_state
);

  localparam int N  = p_WIDTH * p_WORDS;
  localparam int KW = (p_WORDS > 1) ? $clog2(p_WORDS) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(p_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  logic [N-1:0]     r_x;
  logic [N-1:0]     r_y;
  logic             r_cin;
  logic             r_carry;
  logic [KW-1:0]    r_k;
  logic             r_last;
  logic             r_id;
  logic [N:0]       r_sum;

  // Round-robin: on a tie the requester that was not served last wins.
  logic grant0;
  logic grant1;
  assign grant0 = iw_req0_valid & (~iw_req1_valid | r_last);
  assign grant1 = iw_req1_valid & (~iw_req0_valid | ~r_last);

  assign ow_req0_ready = (state == S_IDLE) & grant0;
  assign ow_req1_ready = (state == S_IDLE) & grant1;

  // Current word of the captured operands.
  int                 word_lsb;
  logic [p_WIDTH-1:0] a_word;
  logic [p_WIDTH-1:0] b_word;
  logic               add_cin;
  assign word_lsb = int'(r_k) * p_WIDTH;
  assign a_word   = r_x[word_lsb +: p_WIDTH];
  assign b_word   = r_y[word_lsb +: p_WIDTH];
  // The first word takes the requester's carry-in, later words the chain.
  assign add_cin  = (r_k == '0) ? r_cin : r_carry;

  // Shared carry-lookahead adder: every carry is a flat sum of
  // generate/propagate products rather than a ripple chain.
  logic [p_WIDTH-1:0] gen;
  logic [p_WIDTH-1:0] prop;
  logic [p_WIDTH:0]   carry_vec;
  logic [p_WIDTH-1:0] sum_word;
  assign gen  = a_word & b_word;
  assign prop = a_word ^ b_word;

  always_comb begin : cla
    logic pp;
    logic cc;
    pp        = 1'b1;
    cc        = 1'b0;
    carry_vec = '0;
    carry_vec[0] = add_cin;
    for (int i = 0; i < p_WIDTH; i++) begin
      pp = 1'b1;
      cc = 1'b0;
      for (int j = i; j >= 0; j--) begin
        cc = cc | (pp & gen[j]);
        pp = pp & prop[j];
      end
      carry_vec[i+1] = cc | (pp & add_cin);
    end
    sum_word = prop ^ carry_vec[p_WIDTH-1:0];
  end

  always_ff @(posedge iw_clk or posedge iw_rst) begin
    if (iw_rst) begin
      state   <= S_IDLE;
      r_x     <= '0;
      r_y     <= '0;
      r_cin   <= 1'b0;
      r_carry <= 1'b0;
      r_k     <= '0;
      r_last  <= 1'b1;
      r_id    <= 1'b0;
      r_sum   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant0 | grant1) begin
            r_x    <= grant1 ? iwv_req1_x    : iwv_req0_x;
            r_y    <= grant1 ? iwv_req1_y    : iwv_req0_y;
            r_cin  <= grant1 ? iw_req1_carry : iw_req0_carry;
            r_id   <= grant1;
            r_last <= grant1;
            r_k    <= '0;
            state  <= S_RUN;
          end
        end
        S_RUN: begin
          r_sum[word_lsb +: p_WIDTH] <= sum_word;
          r_carry <= carry_vec[p_WIDTH];
          if (r_k == K_LAST) begin
            r_sum[N] <= carry_vec[p_WIDTH];
            r_k      <= '0;
            state    <= S_DONE;
          end else begin
            r_k <= r_k + KW'(1);
          end
        end
        S_DONE: begin
          if (iw_res_ready) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign ow_res_valid = (state == S_DONE);
  assign owv_res_sum  = r_sum;
  assign ow_res_id    = r_id;
  assign ow_dbg_state = state;

endmodule

// File: doc/add_sequencer.md
# add_sequencer

Multi-precision add scheduler that shares one p_WIDTH-bit `AddrCarryLookAhead` instance between two requesters. Each request carries two p_WIDTH*p_WORDS-bit operands and a carry-in. The block arbitrates round-robin, then feeds the operands to the adder one word per cycle, LSB word first, chaining the carry through a register. It sits between board-level operand sources (switches, GPIO capture logic) and the result display/LED path. It lets one small adder serve wide operands and multiple clients.

## Interface
- p_WIDTH, 8, word width of the shared adder instance
- p_WORDS, 4, words per operand; total operand width N = p_WIDTH*p_WORDS; p_WORDS >= 1
- iw_clk  in  1  single clock; all state on rising edge
- iw_rst  in  1  reset, asynchronous, active-high
- iw_req0_valid  in  1  requester 0 has an operation pending
- iwv_req0_x  in  N  requester 0 operand x
- iwv_req0_y  in  N  requester 0 operand y
- iw_req0_carry  in  1  requester 0 carry-in
- ow_req0_ready  out  1  requester 0 accepted this cycle
- iw_req1_valid, iwv_req1_x, iwv_req1_y, iw_req1_carry, ow_req1_ready: same as requester 0, for requester 1
- ow_res_valid  out  1  result available
- owv_res_sum  out  N+1  x + y + carry-in; bit N is the carry-out
- ow_res_id  out  1  index of the requester that owns the result
- iw_res_ready  in  1  consumer takes the result

## Operation
- FSM states: IDLE, RUN, DONE.
- **IDLE**
  - Grant goes to a valid requester. If both are valid, grant goes to the requester != r_last; r_last resets to 1, so requester 0 wins the first tie.
  - ow_reqN_ready = (state==IDLE) & grantN. It is combinational and never high without the matching valid. At most one ready is high.
  - On a handshake (valid & ready): capture x, y, carry and id; set r_last = id; word index k = 0; go to RUN.
- **RUN**, k = 0..p_WORDS-1
  - Adder inputs: x[k*p_WIDTH +: p_WIDTH], y[k*p_WIDTH +: p_WIDTH].
  - Adder carry-in: the captured carry when k==0, else r_carry.
  - Each cycle: sum word k is written to result[k*p_WIDTH +: p_WIDTH]; adder bit p_WIDTH is written to r_carry; k increments.
  - After the word with k==p_WORDS-1: result[N] = final carry; go to DONE.
- **DONE**
  - ow_res_valid=1; owv_res_sum and ow_res_id are held stable.
  - On iw_res_ready: go to IDLE.
- Arithmetic: the result equals the exact (N+1)-bit sum x + y + cin. There is no wrap, because the carry-out is kept in bit N.
- Operand inputs are don't-care outside the handshake cycle. Requesters need not hold them.
- A requester that is not granted simply waits; its valid may stay high indefinitely, and it is guaranteed service within one operation (round-robin).
- Requests arriving during RUN/DONE see ready=0 and wait.

## Timing
- Reset (async assert, synchronous-to-clock deassert handled upstream):
  - State: IDLE.
  - Outputs: ow_res_valid=0, owv_res_sum=0, ow_res_id=0, both readys=0 until the first valid.
  - Internal: r_carry=0, k=0, r_last=1.
- Latency: handshake at edge E0, RUN occupies the next p_WORDS cycles, and ow_res_valid rises after edge E0+p_WORDS (p_WORDS=4: valid seen in cycle 5 after acceptance).
- Throughput: minimum p_WORDS+2 cycles per operation (RUN x p_WORDS, DONE x1, IDLE x1). The next request cannot be accepted in the same cycle as result consumption.
- Backpressure: DONE holds with all outputs stable for as long as iw_res_ready=0.
- Reset mid-operation (RUN or DONE):
  - Everything returns to reset values immediately and the in-flight operation is discarded without a result. The requester already saw its handshake; it is the system's job to reissue.
  - The first request after reset behaves identically to a power-up request.
- p_WORDS=1: RUN lasts exactly one cycle; the carry-in path is the captured carry only.
- Simultaneous valid rise of both requesters in the same cycle as res consumption: no grant that cycle (still DONE). The grant happens in the following IDLE cycle per r_last.

## Test plan
- **Reset:** assert iw_rst mid-simulation with random inputs. Required: ow_res_valid=0, owv_res_sum=0, ready low with valids low; first tie goes to requester 0.
- **Carry ripple across words** (p_WIDTH=8, p_WORDS=4): req0 x=0xFFFFFFFF, y=0x00000000, carry=1. Required: owv_res_sum=0x1_00000000, ow_res_id=0, valid 4 cycles after the handshake edge. Also x=0x80000000, y=0x80000000, carry=0 -> 0x1_00000000.
- **Arbitration:** both valids held high for 4 operations with distinct operands. Required: served ids 0,1,0,1. Only req1 valid after a req1 grant -> req1 granted again.
- **Backpressure:** iw_res_ready low for 10 cycles in DONE. Required: valid, sum and id constant; both readys 0; a pending request is accepted only after consumption plus one IDLE cycle.
- **Reset mid-RUN:** assert iw_rst at k=2. Required: immediate IDLE, valid 0. Next request x=0x12345678, y=0x11111111, carry=0 -> 0x0_23456789.
- **Random:** 2000 random operations with random valids and ready gaps. Every result is checked against a model computing x+y+cin (N+1 bits), with correct id and round-robin order.
